// File: rtl/lc3_mem_pkg.sv
// Shared types and memory-map constants for the LC-3 MAR/MDR memory-access stage.
package lc3_mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned PAGE_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MEM   = 3'd1,
    ST_DEV   = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam logic [PAGE_W-1:0] MMIO_BASE_HI = 7'h7F;
  localparam logic [ADDR_W-1:0] KBSR_ADDR    = 16'hFE00;
  localparam logic [ADDR_W-1:0] KBDR_ADDR    = 16'hFE02;
  localparam logic [ADDR_W-1:0] DSR_ADDR     = 16'hFE04;
  localparam logic [ADDR_W-1:0] DDR_ADDR     = 16'hFE06;

endpackage

// File: rtl/lc3_mmio_decode.sv
// Combinational decode of an address into the LC-3 device-register selects.
module lc3_mmio_decode
  import lc3_mem_pkg::*;
(
  input  logic [ADDR_W-1:0] mar_i,
  output logic              is_mmio_o,
  output logic              sel_kbsr_o,
  output logic              sel_kbdr_o,
  output logic              sel_dsr_o,
  output logic              sel_ddr_o
);

  // The whole xFE00-xFFFF page routes to devices; only four addresses exist.
  always_comb begin
    is_mmio_o  = (mar_i[ADDR_W-1 -: PAGE_W] == MMIO_BASE_HI);
    sel_kbsr_o = (mar_i == KBSR_ADDR);
    sel_kbdr_o = (mar_i == KBDR_ADDR);
    sel_dsr_o  = (mar_i == DSR_ADDR);
    sel_ddr_o  = (mar_i == DDR_ADDR);
  end

endmodule

// File: rtl/lc3_mem_access.sv
// LC-3 MAR/MDR stage: one memory or device access per MIO.EN request, R pulse on completion.
module lc3_mem_access
  import lc3_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] eab_out,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              ld_mar,
  input  logic              mar_src,
  input  logic              ld_mdr,
  input  logic              mio_en,
  input  logic              r_w,
  output logic [DATA_W-1:0] mar_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic              ready,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] kbsr_in,
  input  logic [DATA_W-1:0] kbdr_in,
  input  logic [DATA_W-1:0] dsr_in,
  output logic              kbdr_rd,
  output logic              ddr_wr,
  output logic [DATA_W-1:0] ddr_data
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e              state_q;
  logic [DATA_W-1:0]   mar_q;
  logic [DATA_W-1:0]   mar_d;
  logic [DATA_W-1:0]   mdr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rw_q;
  logic                ready_q;
  logic                err_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic                kbdr_rd_q;
  logic                ddr_wr_q;
  logic [DATA_W-1:0]   dev_rdata_c;

  logic is_mmio, sel_kbsr, sel_kbdr, sel_dsr, sel_ddr;

  // MAR as the access will see it: an IDLE load lands before a same-cycle start.
  always_comb begin
    mar_d = mar_q;
    if (state_q == ST_IDLE && ld_mar) begin
      mar_d = mar_src ? bus_in : eab_out;
    end
  end

  lc3_mmio_decode u_decode (
    .mar_i      (mar_d),
    .is_mmio_o  (is_mmio),
    .sel_kbsr_o (sel_kbsr),
    .sel_kbdr_o (sel_kbdr),
    .sel_dsr_o  (sel_dsr),
    .sel_ddr_o  (sel_ddr)
  );

  // Device read mux; unpopulated addresses in the device page read as zero.
  always_comb begin
    dev_rdata_c = '0;
    if (sel_kbsr) begin
      dev_rdata_c = kbsr_in;
    end else if (sel_kbdr) begin
      dev_rdata_c = kbdr_in;
    end else if (sel_dsr) begin
      dev_rdata_c = dsr_in;
    end
  end

  // Access FSM with registered handshake, strobe and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mar_q     <= '0;
      mdr_q     <= '0;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      kbdr_rd_q <= 1'b0;
      ddr_wr_q  <= 1'b0;
    end else begin
      ready_q   <= 1'b0;
      kbdr_rd_q <= 1'b0;
      ddr_wr_q  <= 1'b0;
      mar_q     <= mar_d;
      case (state_q)
        ST_IDLE: begin
          if (ld_mdr) begin
            mdr_q <= bus_in;
          end
          if (mio_en) begin
            rw_q  <= r_w;
            err_q <= 1'b0;
            if (is_mmio) begin
              state_q   <= ST_DEV;
              kbdr_rd_q <= !r_w && sel_kbdr;
              ddr_wr_q  <= r_w && sel_ddr;
            end else begin
              state_q  <= ST_MEM;
              cnt_q    <= '0;
              mem_en_q <= 1'b1;
              mem_we_q <= r_w;
            end
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            if (!rw_q) begin
              mdr_q <= mem_rdata;
            end
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= ST_DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            err_q    <= 1'b1;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DEV: begin
          if (!rw_q) begin
            mdr_q <= dev_rdata_c;
          end
          ready_q <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!mio_en) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mar_out   = mar_q;
  assign mdr_out   = mdr_q;
  assign ready     = ready_q;
  assign err       = err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign kbdr_rd   = kbdr_rd_q;
  assign ddr_wr    = ddr_wr_q;
  assign ddr_data  = mdr_q;

endmodule

// File: tb/tb_lc3_mem_access.sv
// Directed self-checking bench for lc3_mem_access (TIMEOUT shortened to 4).
module tb_lc3_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] eab_out, bus_in, mem_rdata, kbsr_in, kbdr_in, dsr_in;
  logic        ld_mar, mar_src, ld_mdr, mio_en, r_w, mem_ack;
  logic [15:0] mar_out, mdr_out, mem_addr, mem_wdata, ddr_data;
  logic        ready, err, mem_en, mem_we, kbdr_rd, ddr_wr;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_cnt = 0, ddr_cnt = 0, kbdr_cnt = 0, mem_en_cnt = 0;
  int r0, d0, k0, m0;

  lc3_mem_access #(.DATA_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .eab_out(eab_out), .bus_in(bus_in),
    .ld_mar(ld_mar), .mar_src(mar_src), .ld_mdr(ld_mdr), .mio_en(mio_en), .r_w(r_w),
    .mar_out(mar_out), .mdr_out(mdr_out), .ready(ready), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .kbsr_in(kbsr_in), .kbdr_in(kbdr_in),
    .dsr_in(dsr_in), .kbdr_rd(kbdr_rd), .ddr_wr(ddr_wr), .ddr_data(ddr_data)
  );

  always #5 clk = ~clk;

  // Count strobe cycles as seen by a downstream sampler at each rising edge.
  always @(posedge clk) begin
    if (ready)   ready_cnt  = ready_cnt + 1;
    if (ddr_wr)  ddr_cnt    = ddr_cnt + 1;
    if (kbdr_rd) kbdr_cnt   = kbdr_cnt + 1;
    if (mem_en)  mem_en_cnt = mem_en_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Device-page read from addr; returns to IDLE afterwards.
  task automatic dev_read(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    eab_out = addr; mar_src = 1'b0; ld_mar = 1'b1; r_w = 1'b0; mio_en = 1'b1;
    step();
    ld_mar = 1'b0;
    chk({tag, "_mem_en"},  32'(mem_en),  32'(0));
    chk({tag, "_kbdr_rd"}, 32'(kbdr_rd), 32'(addr == 16'hFE02));
    chk({tag, "_ready0"},  32'(ready),   32'(0));
    step();
    chk({tag, "_ready"},   32'(ready),   32'(1));
    chk({tag, "_mdr"},     32'(mdr_out), 32'(exp));
    mio_en = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst_n = 1'b0; eab_out = '0; bus_in = '0; ld_mar = 1'b0; mar_src = 1'b0;
    ld_mdr = 1'b0; mio_en = 1'b0; r_w = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    kbsr_in = 16'h8000; kbdr_in = 16'h0041; dsr_in = 16'h8001;
    step();
    step();
    chk("rst_mar",    32'(mar_out), 32'(0));
    chk("rst_mdr",    32'(mdr_out), 32'(0));
    chk("rst_ready",  32'(ready),   32'(0));
    chk("rst_err",    32'(err),     32'(0));
    chk("rst_mem_en", 32'(mem_en),  32'(0));
    chk("rst_strobe", 32'({kbdr_rd, ddr_wr, mem_we}), 32'(0));
    rst_n = 1'b1;
    step();

    // 1: memory read with ack in the first MEM cycle
    eab_out = 16'h3005; mar_src = 1'b0; ld_mar = 1'b1; r_w = 1'b0; mio_en = 1'b1;
    step();
    ld_mar = 1'b0;
    chk("t1_mem_en",   32'(mem_en),   32'(1));
    chk("t1_mem_we",   32'(mem_we),   32'(0));
    chk("t1_mem_addr", 32'(mem_addr), 32'(16'h3005));
    chk("t1_ready0",   32'(ready),    32'(0));
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step();
    mem_ack = 1'b0;
    chk("t1_ready",  32'(ready),   32'(1));
    chk("t1_mdr",    32'(mdr_out), 32'(16'hBEEF));
    chk("t1_mem_en_off", 32'(mem_en), 32'(0));
    mio_en = 1'b0;
    step();
    chk("t1_ready_pulse", 32'(ready), 32'(0));
    // a stray ack outside MEM must not touch MDR
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    chk("stray_ack_mdr", 32'(mdr_out), 32'(16'hBEEF));

    // 2: memory write, ack on the 4th MEM cycle; loads and start share a cycle
    eab_out = 16'h4000; mar_src = 1'b0; ld_mar = 1'b1; bus_in = 16'h1234; ld_mdr = 1'b1;
    r_w = 1'b1; mio_en = 1'b1;
    m0 = mem_en_cnt;
    step();
    ld_mar = 1'b0; ld_mdr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_mem_en",    32'(mem_en),    32'(1));
      chk("t2_mem_we",    32'(mem_we),    32'(1));
      chk("t2_mem_addr",  32'(mem_addr),  32'(16'h4000));
      chk("t2_mem_wdata", 32'(mem_wdata), 32'(16'h1234));
      chk("t2_ready0",    32'(ready),     32'(0));
      if (i == 3) begin
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
      end
      step();
    end
    mem_ack = 1'b0;
    chk("t2_ready",      32'(ready),   32'(1));
    chk("t2_mdr",        32'(mdr_out), 32'(16'h1234));
    chk("t2_mem_en_cyc", 32'(mem_en_cnt - m0), 32'(4));
    mio_en = 1'b0;
    step();
    step();

    // 3: timeout with no ack; err sticky until next accepted access
    eab_out = 16'h5000; ld_mar = 1'b1; r_w = 1'b0; mio_en = 1'b1;
    m0 = mem_en_cnt; r0 = ready_cnt;
    step();
    ld_mar = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_mem_en", 32'(mem_en), 32'(1));
      chk("t3_err0",   32'(err),    32'(0));
      step();
    end
    chk("t3_mem_en_off", 32'(mem_en),  32'(0));
    chk("t3_err",        32'(err),     32'(1));
    chk("t3_ready",      32'(ready),   32'(1));
    chk("t3_mdr",        32'(mdr_out), 32'(16'h1234));
    mio_en = 1'b0;
    step();
    step();
    step();
    chk("t3_err_sticky",   32'(err), 32'(1));
    chk("t3_mem_en_cyc",   32'(mem_en_cnt - m0), 32'(5));
    chk("t3_ready_pulses", 32'(ready_cnt - r0),  32'(1));

    // 4: device reads; the first accepted access clears err
    k0 = kbdr_cnt;
    eab_out = 16'hFE02; ld_mar = 1'b1; r_w = 1'b0; mio_en = 1'b1;
    step();
    ld_mar = 1'b0;
    chk("t4_err_clr", 32'(err), 32'(0));
    mio_en = 1'b0;
    step();
    step();
    step();
    chk("t4_kbdr_pulses", 32'(kbdr_cnt - k0), 32'(1));
    chk("t4_mdr_kbdr", 32'(mdr_out), 32'(16'h0041));
    dev_read(16'hFE02, 16'h0041, "t4_kbdr");
    dev_read(16'hFE00, 16'h8000, "t4_kbsr");
    dev_read(16'hFE04, 16'h8001, "t4_dsr");
    dev_read(16'hFE08, 16'h0000, "t4_hole");

    // 5: DDR write with mio_en held six cycles
    eab_out = 16'hFE06; ld_mar = 1'b1; bus_in = 16'h0058; ld_mdr = 1'b1; r_w = 1'b1; mio_en = 1'b1;
    r0 = ready_cnt; d0 = ddr_cnt; m0 = mem_en_cnt;
    step();
    ld_mar = 1'b0; ld_mdr = 1'b0;
    chk("t5_ddr_wr",   32'(ddr_wr),   32'(1));
    chk("t5_ddr_data", 32'(ddr_data), 32'(16'h0058));
    for (int i = 0; i < 5; i++) step();
    mio_en = 1'b0;
    step();
    step();
    chk("t5_ddr_pulses",   32'(ddr_cnt - d0),    32'(1));
    chk("t5_ready_pulses", 32'(ready_cnt - r0),  32'(1));
    chk("t5_no_mem",       32'(mem_en_cnt - m0), 32'(0));
    chk("t5_mdr",          32'(mdr_out),         32'(16'h0058));

    // 6: load gating during MEM, then reset mid-access
    eab_out = 16'h6000; ld_mar = 1'b1; bus_in = 16'h7777; ld_mdr = 1'b1; r_w = 1'b0; mio_en = 1'b1;
    r0 = ready_cnt;
    step();
    eab_out = 16'hABCD; bus_in = 16'h1111;
    chk("t6_mem_en", 32'(mem_en), 32'(1));
    step();
    chk("t6_mar_gated", 32'(mar_out), 32'(16'h6000));
    chk("t6_mdr_gated", 32'(mdr_out), 32'(16'h7777));
    ld_mar = 1'b0; ld_mdr = 1'b0;
    rst_n = 1'b0;
    step();
    chk("t6_rst_mem_en", 32'(mem_en),  32'(0));
    chk("t6_rst_mar",    32'(mar_out), 32'(0));
    chk("t6_rst_mdr",    32'(mdr_out), 32'(0));
    rst_n = 1'b1; mio_en = 1'b0;
    step();
    step();
    step();
    chk("t6_no_ready", 32'(ready_cnt - r0), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_mem_access.md
Name: lc3_mem_access

Overview:
- MAR/MDR memory-access stage directly downstream of the effective-address block.
- Captures the effective address, or a bus value, into MAR.
- On the control unit's MIO.EN request, performs one read or write. The target is either external memory, using a req/ack handshake, or the LC-3 memory-mapped device registers (xFE00–xFFFF).
- Returns the LC-3 "R" ready signal to the control FSM.

Parameters:
- DATA_W, 16, data/address width; fixed at 16 for LC-3.
- TIMEOUT, 255, maximum wait cycles for mem_ack before the access is aborted with an error.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- eab_out  in  16  effective address from the EAB adder.
- bus_in  in  16  global bus value.
- ld_mar  in  1  load MAR; honoured only in IDLE.
- mar_src  in  1  MAR source: 0 = eab_out, 1 = bus_in.
- ld_mdr  in  1  load MDR from bus_in; honoured only in IDLE.
- mio_en  in  1  start an access, held by the control unit until ready.
- r_w  in  1  access direction: 0 = read, 1 = write; sampled at start.
- mar_out  out  16  MAR contents.
- mdr_out  out  16  MDR contents.
- ready  out  1  R; one-cycle pulse at access completion.
- err  out  1  timeout flag; sticky.
- mem_en  out  1  memory request.
- mem_we  out  1  memory write enable; valid while mem_en is high.
- mem_addr  out  16  equals MAR.
- mem_wdata  out  16  equals MDR.
- mem_rdata  in  16  memory read data; valid when mem_ack is high.
- mem_ack  in  1  memory completion strobe.
- kbsr_in  in  16  keyboard status.
- kbdr_in  in  16  keyboard data.
- dsr_in  in  16  display status.
- kbdr_rd  out  1  one-cycle pulse on a KBDR read; the device uses it to clear its ready bit.
- ddr_wr  out  1  one-cycle pulse on a DDR write.
- ddr_data  out  16  DDR write data (equals MDR).

Behaviour:

Reset:
- Applied when rst_n is low at a rising edge.
- State goes to IDLE. MAR, MDR, and the wait counter go to 0.
- ready, err, mem_en, mem_we, kbdr_rd, and ddr_wr go to 0.
- Reset mid-access abandons the access: mem_en is low from the next cycle and no ready pulse is issued.

Register loads (IDLE only; ignored in all other states):
- ld_mar loads MAR from the source selected by mar_src.
- ld_mdr loads MDR from bus_in.
- If ld_mar/ld_mdr and mio_en are high in the same IDLE cycle, the loads take effect first and the access uses the new values.

FSM states: IDLE, MEM, DEV, DONE, DRAIN.
- IDLE & mio_en: latch r_w.
  - If MAR[15:9] == 7'h7F, go to DEV.
  - Otherwise go to MEM and clear the counter.
- MEM:
  - mem_en = 1 and mem_we = latched r_w.
  - On mem_ack: for a read, MDR <= mem_rdata. Go to DONE.
  - If no ack arrives and counter == TIMEOUT: set err, drop mem_en, leave MDR unchanged, go to DONE.
  - Otherwise increment the counter.
- DEV: single cycle, then go to DONE.
  - Reads load MDR:
    - xFE00 → kbsr_in.
    - xFE02 → kbdr_in, and pulse kbdr_rd.
    - xFE04 → dsr_in.
    - Any other address in the region → 16'h0000.
  - Writes:
    - xFE06 pulses ddr_wr.
    - All other writes are dropped but complete normally.
- DONE: ready = 1 for exactly one cycle, then go to DRAIN.
- DRAIN: wait until mio_en == 0, then go to IDLE. This prevents a held MIO.EN from retriggering.

Latency:
- mio_en seen at edge N gives ready high during cycle N+2 + (number of wait cycles).
- Minimum is 2 cycles: a device access, or memory with ack in the first MEM cycle.

Error flag:
- err clears when the next access is accepted in IDLE.
- err is otherwise sticky until reset.

Write ordering: mem_wdata/ddr_data equal MDR throughout the access. MDR is not modified during a write.

Ack outside MEM: ignored.

Decomposition:
- Package lc3_mem_pkg holds:
  - the state enum,
  - the constants MMIO_BASE_HI = 7'h7F, KBSR_ADDR = 16'hFE00, KBDR_ADDR = 16'hFE02, DSR_ADDR = 16'hFE04, DDR_ADDR = 16'hFE06.
- One sub-module, lc3_mmio_decode: combinational decode of MAR into is_mmio, sel_kbsr, sel_kbdr, sel_dsr, and sel_ddr.

Test Plan:
1. Memory read, zero wait: ld_mar with eab_out = x3005 → mio_en, r_w = 0; mem_ack in the first MEM cycle with mem_rdata = xBEEF → mem_addr = x3005, mdr_out = xBEEF, ready high 2 cycles after start, for 1 cycle.
2. Memory write, 3 wait cycles: MAR = x4000, ld_mdr with bus_in = x1234, r_w = 1 → mem_en/mem_we high for 4 cycles with mem_wdata = x1234; ready 5 cycles after start; MDR still x1234.
3. Timeout: TIMEOUT = 4, mem_ack never asserted → mem_en high for 5 cycles, then drops; err = 1; ready pulses once; MDR unchanged. The next accepted access clears err.
4. MMIO read: MAR = xFE02, kbdr_in = x0041 → no mem_en; kbdr_rd pulses once; mdr_out = x0041; ready 2 cycles after start. MAR = xFE08 → mdr_out = x0000.
5. DDR write plus held mio_en: MAR = xFE06, MDR = x0058, r_w = 1, mio_en held 6 cycles → exactly one ddr_wr pulse with ddr_data = x0058; exactly one ready pulse; no second access until mio_en drops.
6. Reset and load gating: rst_n low during MEM → mem_en = 0 next cycle, no ready, MAR = MDR = 0. ld_mar asserted during a MEM access → MAR unchanged.
